// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: ASCII command-line responder.
// Takes a byte stream such as "jal 10000000\r", optionally echoes each accepted
// byte, and turns each finished line into a command code plus a 32-bit hex argument.
module uart_cmd_parser #(
  parameter int MAX_TOKEN = 8,
  parameter int ECHO      = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [1:0]  cmd_code,
  output logic [31:0] cmd_arg,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        err
);

  localparam logic [2:0] S_CMD     = 3'd0;
  localparam logic [2:0] S_ARG     = 3'd1;
  localparam logic [2:0] S_DISCARD = 3'd2;
  localparam logic [2:0] S_ECHO    = 3'd3;
  localparam logic [2:0] S_EMIT    = 3'd4;

  localparam int            LW      = $clog2(MAX_TOKEN + 1);
  localparam int            TW      = 8 * MAX_TOKEN;
  localparam logic [LW-1:0] MAX_LEN = LW'(MAX_TOKEN);
  localparam bit            ECHO_ON = (ECHO != 0);

  // Hex digit decode: {is_hex, value}.
  function automatic logic [4:0] hex_nibble(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) begin
      return {1'b1, 4'(c - 8'h30)};
    end else if (c >= 8'h61 && c <= 8'h66) begin
      return {1'b1, 4'(c - 8'h57)};
    end else if (c >= 8'h41 && c <= 8'h46) begin
      return {1'b1, 4'(c - 8'h37)};
    end else begin
      return 5'h00;
    end
  endfunction

  logic [2:0]    state_r, state_s, ret_r, ret_s, nxt_s;
  logic          term_r, term_s;
  logic [TW-1:0] token_r, token_s;
  logic [LW-1:0] len_r, len_s;
  logic [31:0]   arg_r, arg_s;
  logic [3:0]    dig_r, dig_s;
  logic          bad_r, bad_s;
  logic          rx_ready_r, tx_valid_r, cmd_valid_r, err_r, err_s;
  logic [7:0]    tx_data_r, tx_data_s;
  logic [1:0]    cmd_code_r, cmd_code_s, code_match_s;
  logic [31:0]   cmd_arg_r, cmd_arg_s;
  logic          accept_s, line_end_s, fire_s;
  logic [4:0]    nib_s;

  assign accept_s  = rx_valid & rx_ready_r;
  assign rx_ready  = rx_ready_r;
  assign tx_data   = tx_data_r;
  assign tx_valid  = tx_valid_r;
  assign cmd_code  = cmd_code_r;
  assign cmd_arg   = cmd_arg_r;
  assign cmd_valid = cmd_valid_r;
  assign err       = err_r;

  // Keyword lookup: exact, case-sensitive, length must match the keyword.
  always_comb begin
    if (len_r == LW'(3) && token_r[23:0] == 24'h6a616c) begin
      code_match_s = 2'd1;
    end else if (len_r == LW'(2) && token_r[15:0] == 16'h6c77) begin
      code_match_s = 2'd2;
    end else if (len_r == LW'(3) && token_r[23:0] == 24'h6c6275) begin
      code_match_s = 2'd3;
    end else begin
      code_match_s = 2'd0;
    end
  end

  // Next-state and datapath: byte classification, echo routing, line termination.
  always_comb begin
    state_s    = state_r;
    ret_s      = ret_r;
    term_s     = term_r;
    token_s    = token_r;
    len_s      = len_r;
    arg_s      = arg_r;
    dig_s      = dig_r;
    bad_s      = bad_r;
    tx_data_s  = tx_data_r;
    cmd_code_s = cmd_code_r;
    cmd_arg_s  = cmd_arg_r;
    err_s      = 1'b0;
    nxt_s      = state_r;
    line_end_s = 1'b0;
    fire_s     = 1'b0;
    nib_s      = hex_nibble(rx_data);

    case (state_r)
      S_CMD: begin
        if (!accept_s) begin
          nxt_s = state_r;
        end else if (rx_data >= 8'h61 && rx_data <= 8'h7a) begin
          if (len_r == MAX_LEN) begin
            bad_s = 1'b1;
            nxt_s = S_DISCARD;
          end else begin
            token_s = {token_r[TW-9:0], rx_data};
            len_s   = len_r + LW'(1);
          end
        end else if (rx_data == 8'h20) begin
          nxt_s = (len_r != '0) ? S_ARG : S_CMD;
        end else if (rx_data == 8'h0a) begin
          nxt_s = S_CMD;
        end else if (rx_data == 8'h0d) begin
          line_end_s = 1'b1;
        end else begin
          bad_s = 1'b1;
          nxt_s = S_DISCARD;
        end
      end
      S_ARG: begin
        if (!accept_s) begin
          nxt_s = state_r;
        end else if (nib_s[4]) begin
          if (dig_r == 4'd8) begin
            bad_s = 1'b1;
            nxt_s = S_DISCARD;
          end else begin
            arg_s = {arg_r[27:0], nib_s[3:0]};
            dig_s = dig_r + 4'd1;
          end
        end else if (rx_data == 8'h20 && dig_r == 4'd0) begin
          nxt_s = S_ARG;
        end else if (rx_data == 8'h0d) begin
          line_end_s = 1'b1;
        end else begin
          bad_s = 1'b1;
          nxt_s = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (accept_s && rx_data == 8'h0d) begin
          line_end_s = 1'b1;
        end else begin
          nxt_s = S_DISCARD;
        end
      end
      S_ECHO: begin
        if (tx_ready) begin
          if (term_r) begin
            fire_s = 1'b1;
          end else begin
            state_s = ret_r;
          end
        end else begin
          state_s = S_ECHO;
        end
      end
      S_EMIT: begin
        if (cmd_ready) begin
          state_s = S_CMD;
        end else begin
          state_s = S_EMIT;
        end
      end
      default: begin
        state_s = S_CMD;
      end
    endcase

    // An accepted byte either detours through the echo state or takes effect at once.
    if (accept_s) begin
      if (ECHO_ON) begin
        state_s   = S_ECHO;
        ret_s     = nxt_s;
        term_s    = line_end_s;
        tx_data_s = rx_data;
      end else if (line_end_s) begin
        fire_s = 1'b1;
      end else begin
        state_s = nxt_s;
      end
    end else begin
      ret_s = ret_r;
    end

    // Line termination: always clears the line context, then emits, flags, or ignores.
    if (fire_s) begin
      token_s = '0;
      len_s   = '0;
      arg_s   = 32'h0000_0000;
      dig_s   = 4'd0;
      bad_s   = 1'b0;
      term_s  = 1'b0;
      if (len_r == '0 && !bad_r) begin
        state_s = S_CMD;
      end else if (code_match_s != 2'd0 && dig_r != 4'd0 && !bad_r) begin
        state_s    = S_EMIT;
        cmd_code_s = code_match_s;
        cmd_arg_s  = arg_r;
      end else begin
        err_s   = 1'b1;
        state_s = S_CMD;
      end
    end else begin
      err_s = 1'b0;
    end
  end

  // State and output registers; handshake outputs follow the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_CMD;
      ret_r       <= S_CMD;
      term_r      <= 1'b0;
      token_r     <= '0;
      len_r       <= '0;
      arg_r       <= 32'h0000_0000;
      dig_r       <= 4'd0;
      bad_r       <= 1'b0;
      rx_ready_r  <= 1'b0;
      tx_valid_r  <= 1'b0;
      tx_data_r   <= 8'h00;
      cmd_valid_r <= 1'b0;
      cmd_code_r  <= 2'd0;
      cmd_arg_r   <= 32'h0000_0000;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      ret_r       <= ret_s;
      term_r      <= term_s;
      token_r     <= token_s;
      len_r       <= len_s;
      arg_r       <= arg_s;
      dig_r       <= dig_s;
      bad_r       <= bad_s;
      rx_ready_r  <= (state_s == S_CMD) || (state_s == S_ARG) || (state_s == S_DISCARD);
      tx_valid_r  <= (state_s == S_ECHO);
      tx_data_r   <= tx_data_s;
      cmd_valid_r <= (state_s == S_EMIT);
      cmd_code_r  <= cmd_code_s;
      cmd_arg_r   <= cmd_arg_s;
      err_r       <= err_s;
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: a line-level model predicts echoes and per-line
// outcomes; one negedge process checks every handshake against it.
module tb_uart_cmd_parser;

  localparam int MAXT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [1:0]  cmd_code;
  logic [31:0] cmd_arg;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic        err;

  logic [7:0]  rx_data0 = 8'h00;
  logic        rx_valid0 = 1'b0;
  logic        rx_ready0;
  logic [7:0]  tx_data0;
  logic        tx_valid0;
  logic [1:0]  cmd_code0;
  logic [31:0] cmd_arg0;
  logic        cmd_valid0;
  logic        err0;

  int vectors = 0;
  int fails = 0;
  int echo_total = 0;
  int cmd_total = 0;
  int err_total = 0;
  logic [1:0]  last_code = 2'd0;
  logic [31:0] last_arg = 32'h0;
  bit tx_mode = 1'b0;
  bit saw_tx0 = 1'b0;

  typedef struct {
    int          kind;   // 1 = command, 2 = error
    logic [1:0]  code;
    logic [31:0] arg;
  } ev_t;

  ev_t        exp_ev[$];
  logic [7:0] exp_echo[$];

  uart_cmd_parser #(.MAX_TOKEN(8), .ECHO(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cmd_code(cmd_code), .cmd_arg(cmd_arg), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .err(err)
  );

  uart_cmd_parser #(.MAX_TOKEN(8), .ECHO(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(1'b1),
    .cmd_code(cmd_code0), .cmd_arg(cmd_arg0), .cmd_valid(cmd_valid0), .cmd_ready(1'b1),
    .err(err0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic int hexval(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    return -1;
  endfunction

  // Line-level model: what one line (without its CR) must produce.
  function automatic void model_line(input string s, output int kind,
                                     output logic [1:0] code, output logic [31:0] arg);
    logic [63:0] w;
    logic [7:0]  c;
    int wl, dg, v;
    bit bad, in_arg;
    w = 64'h0; wl = 0; dg = 0; bad = 1'b0; in_arg = 1'b0; arg = 32'h0; code = 2'd0;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      v = hexval(c);
      if (bad) continue;
      if (!in_arg) begin
        if (c >= "a" && c <= "z") begin
          if (wl == MAXT) bad = 1'b1;
          else begin w = {w[55:0], c}; wl++; end
        end else if (c == " ") begin
          if (wl > 0) in_arg = 1'b1;
        end else if (c != 8'h0a) begin
          bad = 1'b1;
        end
      end else begin
        if (v >= 0) begin
          if (dg == 8) bad = 1'b1;
          else begin arg = arg * 32'd16 + 32'(v); dg++; end
        end else if (!(c == " " && dg == 0)) begin
          bad = 1'b1;
        end
      end
    end
    if (bad) kind = 2;
    else if (wl == 0) kind = 0;
    else begin
      if (wl == 3 && w[23:0] == "jal") code = 2'd1;
      else if (wl == 2 && w[15:0] == "lw") code = 2'd2;
      else if (wl == 3 && w[23:0] == "lbu") code = 2'd3;
      kind = (code != 2'd0 && dg > 0) ? 1 : 2;
      if (kind == 2) code = 2'd0;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b);
    bit got = 1'b0;
    rx_data = b;
    rx_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (rx_ready) begin got = 1'b1; break; end
    end
    if (!got) begin
      vectors++; fails++;
      $display("FAIL rx_accept_timeout: byte %h not accepted, required acceptance", b);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_line(input string s, input bit with_cr);
    int kind; logic [1:0] code; logic [31:0] arg; ev_t e;
    model_line(s, kind, code, arg);
    for (int i = 0; i < s.len(); i++) exp_echo.push_back(s[i]);
    if (with_cr) begin
      exp_echo.push_back(8'h0d);
      if (kind != 0) begin
        e.kind = kind; e.code = code; e.arg = arg;
        exp_ev.push_back(e);
      end
    end
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    if (with_cr) send_byte(8'h0d);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (exp_echo.size() == 0 && exp_ev.size() == 0 && !tx_valid && !cmd_valid) begin
        ok = 1'b1; break;
      end
    end
    vectors++;
    if (!ok) begin
      fails++;
      $display("FAIL drain_timeout: %0d echoes and %0d events outstanding, required 0",
               exp_echo.size(), exp_ev.size());
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic send0(input logic [7:0] b, input bit check_ready);
    bit got = 1'b0;
    rx_data0 = b;
    rx_valid0 = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rx_ready0) begin got = 1'b1; break; end
    end
    chk("echo0_accept", got, 1'b1);
    @(posedge clk); #1;
    rx_valid0 = 1'b0;
    if (check_ready) begin
      @(negedge clk);
      chk("echo0_rx_ready_next", rx_ready0, 1'b1);
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, rx_ready, 1'b0);
    chk({tag, "_tx_valid"}, tx_valid, 1'b0);
    chk({tag, "_tx_data"}, tx_data, 8'h00);
    chk({tag, "_cmd_valid"}, cmd_valid, 1'b0);
    chk({tag, "_cmd_code"}, cmd_code, 2'd0);
    chk({tag, "_cmd_arg"}, cmd_arg, 32'h0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_rx_ready0"}, rx_ready0, 1'b0);
  endtask

  // Transmit-ready driver: always ready, or toggling every 3 cycles.
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (tx_mode) begin
        cnt++;
        if (cnt == 3) begin cnt = 0; tx_ready = !tx_ready; end
      end else begin
        tx_ready = 1'b1;
      end
    end
  end

  // Compare process: checks every echo and command handshake, stability and err pulses.
  always @(negedge clk) begin : cmp
    ev_t e;
    logic [7:0] b;
    static bit hold_tx = 1'b0, hold_cmd = 1'b0, prev_err = 1'b0;
    static logic [7:0] hold_txd = 8'h00;
    static logic [1:0] hold_code = 2'd0;
    static logic [31:0] hold_arg = 32'h0;
    if (!rst_n) begin
      hold_tx = 1'b0; hold_cmd = 1'b0; prev_err = 1'b0;
    end else begin
      if (hold_tx) chk("tx_hold", {tx_valid, tx_data}, {1'b1, hold_txd});
      if (tx_valid && tx_ready) begin
        echo_total++;
        if (exp_echo.size() == 0) begin
          vectors++; fails++;
          $display("FAIL echo_unexpected: tx_data=%h, required no echo", tx_data);
        end else begin
          b = exp_echo.pop_front();
          chk("echo_byte", tx_data, b);
        end
      end
      if (hold_cmd) chk("cmd_hold", {cmd_valid, cmd_code, cmd_arg}, {1'b1, hold_code, hold_arg});
      if (cmd_valid) chk("rx_ready_in_emit", rx_ready, 1'b0);
      if (cmd_valid && cmd_ready) begin
        cmd_total++;
        last_code = cmd_code;
        last_arg = cmd_arg;
        if (exp_ev.size() == 0) begin
          vectors++; fails++;
          $display("FAIL cmd_unexpected: code=%0d arg=%h, required none", cmd_code, cmd_arg);
        end else begin
          e = exp_ev.pop_front();
          chk("cmd_kind", 32'(1), 32'(e.kind));
          chk("cmd_code", cmd_code, e.code);
          chk("cmd_arg", cmd_arg, e.arg);
        end
      end
      if (err) begin
        err_total++;
        chk("err_prev_cycle", prev_err, 1'b0);
        if (exp_ev.size() == 0) begin
          vectors++; fails++;
          $display("FAIL err_unexpected: err=1, required 0");
        end else begin
          e = exp_ev.pop_front();
          chk("err_kind", 32'(2), 32'(e.kind));
        end
      end
      hold_tx = tx_valid && !tx_ready;
      hold_txd = tx_data;
      hold_cmd = cmd_valid && !cmd_ready;
      hold_code = cmd_code;
      hold_arg = cmd_arg;
      prev_err = err;
    end
  end

  // Echo-free instance must never raise tx_valid.
  always @(negedge clk) begin
    if (tx_valid0) saw_tx0 = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind; logic [1:0] code; logic [31:0] arg;
    int c0, e0, x0;
    bit got;
    string s0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Pin the model with hand-computed outcomes.
    model_line("jal 10000000", kind, code, arg);
    chk("model_jal_kind", kind, 1); chk("model_jal_code", code, 2'd1); chk("model_jal_arg", arg, 32'h10000000);
    model_line("lw   1F", kind, code, arg);
    chk("model_lw_code", code, 2'd2); chk("model_lw_arg", arg, 32'h0000001F);
    model_line("xyz 12", kind, code, arg);
    chk("model_xyz_kind", kind, 2);
    model_line("jal 123456789", kind, code, arg);
    chk("model_9dig_kind", kind, 2);
    model_line("", kind, code, arg);
    chk("model_empty_kind", kind, 0);
    model_line("lbu ab", kind, code, arg);
    chk("model_lbu_arg", arg, 32'h000000AB);
    model_line("lwx 5", kind, code, arg);
    chk("model_lwx_kind", kind, 2);
    @(posedge clk); #1;

    // jal with tx always ready.
    c0 = cmd_total; e0 = err_total; x0 = echo_total;
    send_line("jal 10000000", 1'b1);
    drain();
    chk("jal_echo_count", echo_total - x0, 13);
    chk("jal_cmd_count", cmd_total - c0, 1);
    chk("jal_err_count", err_total - e0, 0);
    chk("jal_code", last_code, 2'd1);
    chk("jal_arg", last_arg, 32'h10000000);

    // lw with tx_ready toggling.
    tx_mode = 1'b1;
    send_line("lw   1F", 1'b1);
    drain();
    tx_mode = 1'b0;
    chk("lw_code", last_code, 2'd2);
    chk("lw_arg", last_arg, 32'h0000001F);

    // Two malformed lines.
    c0 = cmd_total; e0 = err_total;
    send_line("xyz 12", 1'b1);
    drain();
    send_line("jal 123456789", 1'b1);
    drain();
    chk("bad_err_count", err_total - e0, 2);
    chk("bad_cmd_count", cmd_total - c0, 0);

    // Unknown keyword and word too long.
    e0 = err_total;
    send_line("lwx 5", 1'b1);
    drain();
    send_line("abcdefghi 1", 1'b1);
    drain();
    chk("kw_err_count", err_total - e0, 2);

    // lbu with consumer stalled for 10 cycles.
    cmd_ready = 1'b0;
    send_line("lbu ab", 1'b1);
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cmd_valid) begin got = 1'b1; break; end
    end
    chk("lbu_valid_seen", got, 1'b1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      chk("lbu_stall_valid", cmd_valid, 1'b1);
      chk("lbu_stall_code", cmd_code, 2'd3);
      chk("lbu_stall_arg", cmd_arg, 32'h000000AB);
      chk("lbu_stall_rx_ready", rx_ready, 1'b0);
    end
    @(posedge clk); #1;
    cmd_ready = 1'b1;
    drain();
    c0 = cmd_total; e0 = err_total;
    send_line("", 1'b1);
    drain();
    chk("empty_cmd_count", cmd_total - c0, 0);
    chk("empty_err_count", err_total - e0, 0);

    // Reset in the middle of a line.
    send_line("jal 100", 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_echo.delete();
    exp_ev.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    c0 = cmd_total; e0 = err_total;
    send_line("jal 4", 1'b1);
    drain();
    chk("postreset_cmd_count", cmd_total - c0, 1);
    chk("postreset_err_count", err_total - e0, 0);
    chk("postreset_arg", last_arg, 32'h00000004);
    chk("postreset_code", last_code, 2'd1);

    // Echo-free instance.
    s0 = "lw 8";
    for (int i = 0; i < s0.len(); i++) send0(s0[i], 1'b1);
    send0(8'h0d, 1'b0);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cmd_valid0) begin got = 1'b1; break; end
    end
    chk("echo0_cmd_valid", got, 1'b1);
    chk("echo0_code", cmd_code0, 2'd2);
    chk("echo0_arg", cmd_arg0, 32'h00000008);
    chk("echo0_err", err0, 1'b0);
    chk("echo0_no_tx", saw_tx0, 1'b0);
    chk("echo0_tx_data", tx_data0, 8'h00);

    chk("queues_empty", exp_echo.size() + exp_ev.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
